// File: rtl/abr_prim_count_bank.sv
// Bank of independent hardened up/down cross-counters with saturate/wrap mode,
// terminal-count pulse and an aggregated invariant-violation alert.
module abr_prim_count_bank #(
    parameter int                 NumChan    = 4,
    parameter int                 Width      = 8,
    parameter logic [Width-1:0]   ResetValue = '0,
    parameter bit                 ErrSticky  = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_b,
    input  logic [NumChan-1:0]         clr_i,
    input  logic [NumChan-1:0]         set_i,
    input  logic [NumChan*Width-1:0]   set_cnt_i,
    input  logic [NumChan-1:0]         incr_en_i,
    input  logic [NumChan-1:0]         decr_en_i,
    input  logic [NumChan*Width-1:0]   step_i,
    input  logic [NumChan-1:0]         wrap_i,
    input  logic [NumChan*Width-1:0]   tc_val_i,
    output logic [NumChan*Width-1:0]   cnt_o,
    output logic [NumChan-1:0]         tc_o,
    output logic [NumChan-1:0]         err_chan_o,
    output logic                       err_o
);

    for (genvar c = 0; c < NumChan; c++) begin : g_chan
        logic [Width-1:0] cnt_q, cnt_d, sec_q, sec_d;
        logic [Width-1:0] set_v, step_v, tc_v;
        logic [Width:0]   inc_p, dec_p, inc_s, dec_s, sum_chk;
        logic             upd, load_evt, raw_err, tc_q, err_q;

        assign set_v  = set_cnt_i[c*Width +: Width];
        assign step_v = step_i[c*Width +: Width];
        assign tc_v   = tc_val_i[c*Width +: Width];

        // Primary and secondary use separate adders so a fault in either flop
        // cannot be masked by deriving one from the other.
        always_comb begin
            inc_p = {1'b0, cnt_q} + {1'b0, step_v};
            dec_p = {1'b0, cnt_q} - {1'b0, step_v};
            inc_s = {1'b0, sec_q} + {1'b0, step_v};
            dec_s = {1'b0, sec_q} - {1'b0, step_v};
            cnt_d = cnt_q;
            sec_d = sec_q;
            upd   = 1'b1;
            if (clr_i[c]) begin
                cnt_d = ResetValue;
                sec_d = ~ResetValue;
            end else if (set_i[c]) begin
                cnt_d = set_v;
                sec_d = ~set_v;
            end else if (incr_en_i[c] && !decr_en_i[c]) begin
                upd   = wrap_i[c] || (cnt_q != {Width{1'b1}});
                cnt_d = (inc_p[Width] && !wrap_i[c]) ? {Width{1'b1}} : inc_p[Width-1:0];
                sec_d = (dec_s[Width] && !wrap_i[c]) ? {Width{1'b0}} : dec_s[Width-1:0];
            end else if (decr_en_i[c] && !incr_en_i[c]) begin
                upd   = wrap_i[c] || (cnt_q != {Width{1'b0}});
                cnt_d = (dec_p[Width] && !wrap_i[c]) ? {Width{1'b0}} : dec_p[Width-1:0];
                sec_d = (inc_s[Width] && !wrap_i[c]) ? {Width{1'b1}} : inc_s[Width-1:0];
            end
        end

        assign load_evt = clr_i[c] | set_i[c];
        assign sum_chk  = {1'b0, cnt_q} + {1'b0, sec_q};
        assign raw_err  = (sum_chk != {1'b0, {Width{1'b1}}});

        always_ff @(posedge clk_i) begin
            if (!rst_b) begin
                cnt_q <= ResetValue;
                sec_q <= ~ResetValue;
                tc_q  <= 1'b0;
                err_q <= 1'b0;
            end else begin
                if (upd) begin
                    cnt_q <= cnt_d;
                    sec_q <= sec_d;
                end
                tc_q  <= (cnt_d == tc_v) && ((cnt_q != tc_v) || load_evt);
                err_q <= err_q | raw_err;
            end
        end

        assign cnt_o[c*Width +: Width] = cnt_q;
        assign tc_o[c]                 = tc_q;
        assign err_chan_o[c]           = ErrSticky ? err_q : raw_err;
    end

    assign err_o = |err_chan_o;

endmodule

// File: tb/tb_abr_prim_count_bank.sv
// Scoreboard bench for abr_prim_count_bank: a behavioural integer model pushes
// expected outputs each cycle; each test pops and compares after the clock edge.
module tb_abr_prim_count_bank;
    logic        clk_i = 1'b0;
    logic        rst_b;
    logic [3:0]  clr_i, set_i, incr_en_i, decr_en_i, wrap_i;
    logic [31:0] set_cnt_i, step_i, tc_val_i;
    logic [31:0] cnt_o;
    logic [3:0]  tc_o, err_chan_o;
    logic        err_o;

    abr_prim_count_bank dut (
        .clk_i(clk_i), .rst_b(rst_b), .clr_i(clr_i), .set_i(set_i),
        .set_cnt_i(set_cnt_i), .incr_en_i(incr_en_i), .decr_en_i(decr_en_i),
        .step_i(step_i), .wrap_i(wrap_i), .tc_val_i(tc_val_i),
        .cnt_o(cnt_o), .tc_o(tc_o), .err_chan_o(err_chan_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] cnt;
        logic [3:0]  tc;
        logic [3:0]  errc;
        logic        err;
    } exp_t;

    exp_t       sb[$];
    int         nvec = 0;
    int         nfail = 0;
    int         m_cnt[4];
    logic [3:0] m_errc;
    logic [7:0] fault_val;

    task automatic idle();
        clr_i = '0; set_i = '0; incr_en_i = '0; decr_en_i = '0;
    endtask

    // Behavioural next-state model; pushes expected outputs then advances one clock.
    task automatic step_cycle();
        exp_t e;
        int   v, n, tcv;
        bit   ld;
        e.cnt = '0; e.tc = '0;
        for (int c = 0; c < 4; c++) begin
            tcv = int'(tc_val_i[c*8 +: 8]);
            ld  = clr_i[c] || set_i[c];
            if (!rst_b) begin
                n = 0;
                e.tc[c] = 1'b0;
            end else begin
                if (clr_i[c]) n = 0;
                else if (set_i[c]) n = int'(set_cnt_i[c*8 +: 8]);
                else if (incr_en_i[c] && !decr_en_i[c]) begin
                    v = m_cnt[c] + int'(step_i[c*8 +: 8]);
                    n = (v > 255) ? (wrap_i[c] ? v - 256 : 255) : v;
                end else if (decr_en_i[c] && !incr_en_i[c]) begin
                    v = m_cnt[c] - int'(step_i[c*8 +: 8]);
                    n = (v < 0) ? (wrap_i[c] ? v + 256 : 0) : v;
                end else n = m_cnt[c];
                e.tc[c] = (n == tcv) && (m_cnt[c] != tcv || ld);
            end
            m_cnt[c] = n;
            e.cnt[c*8 +: 8] = 8'(n);
        end
        if (!rst_b) m_errc = '0;
        e.errc = m_errc;
        e.err  = |m_errc;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        idle();
        rst_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) rst_b = 1'b1;
            step_cycle();
            e = sb.pop_front(); nvec++;
            if ({cnt_o, tc_o, err_chan_o, err_o} !== {e.cnt, e.tc, e.errc, e.err}) begin
                nfail++;
                $display("FAIL reset[%0d]: got cnt=%h tc=%b err=%b/%b want cnt=%h tc=%b err=%b/%b",
                         i, cnt_o, tc_o, err_chan_o, err_o, e.cnt, e.tc, e.errc, e.err);
            end
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        logic [7:0] sec_want;
        for (int i = 0; i < 4; i++) begin
            idle();
            wrap_i[0] = 1'b0;
            step_i[7:0] = 8'd3;
            if (i == 0) begin set_i[0] = 1'b1; set_cnt_i[7:0] = 8'd250; end
            else incr_en_i[0] = 1'b1;
            step_cycle();
            e = sb.pop_front(); nvec++;
            if ({cnt_o, tc_o, err_chan_o, err_o} !== {e.cnt, e.tc, e.errc, e.err}) begin
                nfail++;
                $display("FAIL saturate[%0d]: got cnt=%h tc=%b err=%b want cnt=%h tc=%b err=%b",
                         i, cnt_o, tc_o, err_o, e.cnt, e.tc, e.err);
            end
            sec_want = 8'(255 - m_cnt[0]);
            nvec++;
            if (dut.g_chan[0].sec_q !== sec_want) begin
                nfail++;
                $display("FAIL saturate_sec[%0d]: got %0d want %0d", i, dut.g_chan[0].sec_q, sec_want);
            end
        end
        idle();
    endtask

    task automatic test_wrap();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            idle();
            wrap_i[1] = 1'b1;
            case (i)
                0: begin set_i[1] = 1'b1; set_cnt_i[15:8] = 8'd254; end
                1: begin incr_en_i[1] = 1'b1; step_i[15:8] = 8'd3; end
                default: begin decr_en_i[1] = 1'b1; step_i[15:8] = 8'd2; end
            endcase
            step_cycle();
            e = sb.pop_front(); nvec++;
            if ({cnt_o, tc_o, err_chan_o, err_o} !== {e.cnt, e.tc, e.errc, e.err}) begin
                nfail++;
                $display("FAIL wrap[%0d]: got cnt=%h tc=%b err=%b want cnt=%h tc=%b err=%b",
                         i, cnt_o, tc_o, err_o, e.cnt, e.tc, e.err);
            end
        end
        idle();
    endtask

    task automatic test_terminal_count();
        exp_t e;
        int   pulses = 0;
        for (int i = 0; i < 11; i++) begin
            idle();
            step_i[23:16] = 8'd1;
            if (i == 0) clr_i[2] = 1'b1;
            else if (i <= 7) incr_en_i[2] = 1'b1;
            else if (i == 8 || i == 10) begin set_i[2] = 1'b1; set_cnt_i[23:16] = 8'd5; end
            step_cycle();
            e = sb.pop_front(); nvec++;
            if ({cnt_o, tc_o, err_chan_o, err_o} !== {e.cnt, e.tc, e.errc, e.err}) begin
                nfail++;
                $display("FAIL tc[%0d]: got cnt=%h tc=%b want cnt=%h tc=%b",
                         i, cnt_o, tc_o, e.cnt, e.tc);
            end
            if (tc_o[2] === 1'b1) pulses++;
        end
        nvec++;
        if (pulses !== 3) begin
            nfail++;
            $display("FAIL tc_pulse_count: got %0d want 3", pulses);
        end
        idle();
    endtask

    task automatic test_priority();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            idle();
            step_i = {8'd4, 8'd2, 8'd1, 8'd6};
            set_cnt_i[31:24] = 8'd77;
            incr_en_i = 4'b1001;
            case (i)
                0: begin clr_i[3] = 1'b1; set_i[3] = 1'b1; end
                1: set_i[3] = 1'b1;
                default: decr_en_i[3] = 1'b1;
            endcase
            step_cycle();
            e = sb.pop_front(); nvec++;
            if ({cnt_o, tc_o, err_chan_o, err_o} !== {e.cnt, e.tc, e.errc, e.err}) begin
                nfail++;
                $display("FAIL priority[%0d]: got cnt=%h tc=%b want cnt=%h tc=%b",
                         i, cnt_o, tc_o, e.cnt, e.tc);
            end
        end
        idle();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 60; i++) begin
            for (int c = 0; c < 4; c++) begin
                clr_i[c]     = ($urandom_range(0, 15) == 0);
                set_i[c]     = ($urandom_range(0, 7) == 0);
                incr_en_i[c] = $urandom_range(0, 1) == 1;
                decr_en_i[c] = $urandom_range(0, 2) == 0;
                wrap_i[c]    = $urandom_range(0, 1) == 1;
                step_i[c*8 +: 8]    = 8'($urandom_range(0, 90));
                set_cnt_i[c*8 +: 8] = 8'($urandom_range(0, 255));
            end
            step_cycle();
            e = sb.pop_front(); nvec++;
            if ({cnt_o, tc_o, err_chan_o, err_o} !== {e.cnt, e.tc, e.errc, e.err}) begin
                nfail++;
                $display("FAIL back_to_back[%0d]: got cnt=%h tc=%b err=%b want cnt=%h tc=%b err=%b",
                         i, cnt_o, tc_o, err_o, e.cnt, e.tc, e.err);
            end
        end
        idle();
    endtask

    task automatic test_fault();
        exp_t e;
        fault_val = 8'(255 - m_cnt[1] + 1);
        force dut.g_chan[1].sec_q = fault_val;
        m_errc = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i == 1) release dut.g_chan[1].sec_q;
            if (i >= 3) begin incr_en_i[0] = 1'b1; step_i[7:0] = 8'd1; wrap_i[0] = 1'b1; end
            if (i == 5) rst_b = 1'b0;
            step_cycle();
            e = sb.pop_front(); nvec++;
            if ({cnt_o, tc_o, err_chan_o, err_o} !== {e.cnt, e.tc, e.errc, e.err}) begin
                nfail++;
                $display("FAIL fault[%0d]: got cnt=%h tc=%b err=%b/%b want cnt=%h tc=%b err=%b/%b",
                         i, cnt_o, tc_o, err_chan_o, err_o, e.cnt, e.tc, e.errc, e.err);
            end
        end
        rst_b = 1'b1;
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < 4; c++) m_cnt[c] = 0;
        m_errc    = '0;
        fault_val = '0;
        wrap_i    = '0;
        set_cnt_i = '0;
        step_i    = '0;
        tc_val_i  = {8'd40, 8'd5, 8'd1, 8'd253};
        idle();
        rst_b = 1'b0;
        test_reset();
        test_saturate();
        test_wrap();
        test_terminal_count();
        test_priority();
        test_back_to_back();
        test_fault();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
